// File: rtl/writeback_arbiter.sv
// Per-channel result FIFOs feeding a round-robin arbiter and a single stallable
// writeback register. A pushed entry can reach the writeback register at the earliest one edge after its push.

module wb_chan_fifo #(
    parameter int W     = 70,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         ready_o,
    output logic         empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;

    assign ready_o = (count < CNT_W'(DEPTH));
    assign empty_o = (count == '0);
    assign push_ok = push_i & ready_o;
    assign head_o  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push_ok)
            mem[wr_ptr] <= din_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_i)   rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_i})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module writeback_arbiter #(
    parameter  int NUM_CH = 2,
    parameter  int DEPTH  = 4,
    localparam int SRC_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NUM_CH-1:0]    valid_i,
    output logic [NUM_CH-1:0]    ready_o,
    input  logic [NUM_CH*32-1:0] instr_i,
    input  logic [NUM_CH*32-1:0] result_i,
    input  logic [NUM_CH*5-1:0]  rd_i,
    input  logic [NUM_CH-1:0]    reg_write_i,
    input  logic                 stall_w_i,
    output logic [31:0]          instr_w_o,
    output logic [31:0]          result_w_o,
    output logic [4:0]           rd_w_o,
    output logic                 reg_write_w_o,
    output logic                 valid_w_o,
    output logic                 retire_w_o,
    output logic [SRC_W-1:0]     src_w_o
);
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] result;
        logic [4:0]  rd;
        logic        reg_write;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

    wb_entry_t [NUM_CH-1:0] push_data, head_data;
    logic      [NUM_CH-1:0] empty, pop;
    logic      [SRC_W-1:0]  last_grant, grant_idx;
    logic                   found;
    wb_entry_t              grant_entry;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign push_data[k] = {instr_i[32*k +: 32], result_i[32*k +: 32],
                               rd_i[5*k +: 5], reg_write_i[k]};
        assign pop[k] = ~stall_w_i & found & (grant_idx == SRC_W'(k));

        wb_chan_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .push_i  (valid_i[k]),
            .din_i   (push_data[k]),
            .pop_i   (pop[k]),
            .head_o  (head_data[k]),
            .ready_o (ready_o[k]),
            .empty_o (empty[k])
        );
    end

    // Scan starts one past the last winner so every channel gets a turn.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            int               sum;
            logic [SRC_W-1:0] cand;
            sum = int'(last_grant) + 1 + i;
            if (sum >= NUM_CH) sum = sum - NUM_CH;
            cand = SRC_W'(sum);
            if (!found && !empty[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant_entry = head_data[grant_idx];
    assign retire_w_o  = valid_w_o & ~stall_w_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_grant    <= SRC_W'(NUM_CH - 1);
            instr_w_o     <= '0;
            result_w_o    <= '0;
            rd_w_o        <= '0;
            reg_write_w_o <= 1'b0;
            valid_w_o     <= 1'b0;
            src_w_o       <= '0;
        end else if (!stall_w_i) begin
            if (found) begin
                last_grant    <= grant_idx;
                instr_w_o     <= grant_entry.instr;
                result_w_o    <= grant_entry.result;
                rd_w_o        <= grant_entry.rd;
                reg_write_w_o <= grant_entry.reg_write;
                valid_w_o     <= 1'b1;
                src_w_o       <= grant_idx;
            end else begin
                instr_w_o     <= '0;
                result_w_o    <= '0;
                rd_w_o        <= '0;
                reg_write_w_o <= 1'b0;
                valid_w_o     <= 1'b0;
                src_w_o       <= '0;
            end
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with NUM_CH=2, DEPTH=4.
module tb_writeback_arbiter;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [1:0]  valid_i;
    logic [1:0]  ready_o;
    logic [63:0] instr_i, result_i;
    logic [9:0]  rd_i;
    logic [1:0]  reg_write_i;
    logic        stall_w_i;
    logic [31:0] instr_w_o, result_w_o;
    logic [4:0]  rd_w_o;
    logic        reg_write_w_o, valid_w_o, retire_w_o;
    logic [0:0]  src_w_o;

    int n_cmp = 0;
    int n_err = 0;

    writeback_arbiter #(.NUM_CH(2), .DEPTH(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
        .instr_i(instr_i), .result_i(result_i), .rd_i(rd_i), .reg_write_i(reg_write_i),
        .stall_w_i(stall_w_i), .instr_w_o(instr_w_o), .result_w_o(result_w_o),
        .rd_w_o(rd_w_o), .reg_write_w_o(reg_write_w_o), .valid_w_o(valid_w_o),
        .retire_w_o(retire_w_o), .src_w_o(src_w_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input int ch, input logic [31:0] instr, input logic [31:0] res,
                         input logic [4:0] rd, input logic rw);
        valid_i[ch]          = 1'b1;
        instr_i[32*ch +: 32] = instr;
        result_i[32*ch +: 32] = res;
        rd_i[5*ch +: 5]      = rd;
        reg_write_i[ch]      = rw;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        valid_i = '0;
        tick();
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        stall_w_i = 1'b1;
        drive(0, 32'h11, 32'hBAD0, 5'd3, 1'b1);
        tick();
        reset_i = 1'b0;
        valid_i = '0;
        n_cmp++;
        if (ready_o !== 2'b11) begin
            n_err++; $display("FAIL reset_ready: got %b want 11", ready_o);
        end
        n_cmp++;
        if ({valid_w_o, retire_w_o, reg_write_w_o} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags: got %b want 000", {valid_w_o, retire_w_o, reg_write_w_o});
        end
        n_cmp++;
        if ({instr_w_o, result_w_o, rd_w_o, src_w_o} !== 70'd0) begin
            n_err++; $display("FAIL reset_fields: got %h want 0", {instr_w_o, result_w_o, rd_w_o, src_w_o});
        end
        stall_w_i = 1'b0;
        tick();
        n_cmp++;
        if (valid_w_o !== 1'b0) begin
            n_err++; $display("FAIL reset_push_discarded: valid %b want 0", valid_w_o);
        end
    endtask

    task automatic test_single();
        do_reset();
        drive(0, 32'hA0A0_0001, 32'h1234, 5'd5, 1'b1);
        tick();
        valid_i = '0;
        n_cmp++;
        if (valid_w_o !== 1'b0) begin
            n_err++; $display("FAIL single_no_bypass: valid %b want 0", valid_w_o);
        end
        tick();
        n_cmp++;
        if ({valid_w_o, result_w_o, rd_w_o, src_w_o, retire_w_o} !== {1'b1, 32'h1234, 5'd5, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL single_out: v=%b res=%h rd=%0d src=%0d ret=%b want 1 1234 5 0 1",
                              valid_w_o, result_w_o, rd_w_o, src_w_o, retire_w_o);
        end
        n_cmp++;
        if ({instr_w_o, reg_write_w_o} !== {32'hA0A0_0001, 1'b1}) begin
            n_err++; $display("FAIL single_instr_rw: instr=%h rw=%b want a0a00001 1", instr_w_o, reg_write_w_o);
        end
        tick();
        n_cmp++;
        if ({valid_w_o, reg_write_w_o, retire_w_o} !== 3'b000) begin
            n_err++; $display("FAIL single_bubble: got %b want 000", {valid_w_o, reg_write_w_o, retire_w_o});
        end
    endtask

    task automatic test_fairness();
        do_reset();
        stall_w_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h0, 32'h100 + i, 5'd1 + 5'(i), 1'b1);
            drive(1, 32'h0, 32'h200 + i, 5'd10 + 5'(i), 1'b0);
            tick();
        end
        valid_i = '0;
        n_cmp++;
        if (ready_o !== 2'b11) begin
            n_err++; $display("FAIL fair_ready_3: got %b want 11", ready_o);
        end
        stall_w_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic        es;
            logic [31:0] er;
            logic [4:0]  ed;
            tick();
            es = 1'(i % 2);
            er = (es ? 32'h200 : 32'h100) + 32'(i / 2);
            ed = (es ? 5'd10 : 5'd1) + 5'(i / 2);
            n_cmp++;
            if ({valid_w_o, src_w_o, result_w_o, rd_w_o, reg_write_w_o} !== {1'b1, es, er, ed, ~es}) begin
                n_err++; $display("FAIL fair_grant%0d: v=%b src=%0d res=%h rd=%0d rw=%b want 1 %0d %h %0d %b",
                                  i, valid_w_o, src_w_o, result_w_o, rd_w_o, reg_write_w_o, es, er, ed, ~es);
            end
        end
        tick();
        n_cmp++;
        if ({valid_w_o, reg_write_w_o} !== 2'b00) begin
            n_err++; $display("FAIL fair_bubble: got %b want 00", {valid_w_o, reg_write_w_o});
        end
    endtask

    task automatic test_full();
        do_reset();
        stall_w_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h0, 32'h300 + i, 5'd7, 1'b1);
            tick();
        end
        n_cmp++;
        if (ready_o !== 2'b01) begin
            n_err++; $display("FAIL full_ready: got %b want 01", ready_o);
        end
        drive(1, 32'h0, 32'hDEAD, 5'd7, 1'b1);
        tick();
        valid_i = '0;
        n_cmp++;
        if (ready_o !== 2'b01) begin
            n_err++; $display("FAIL full_drop_ready: got %b want 01", ready_o);
        end
        stall_w_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({valid_w_o, src_w_o, result_w_o} !== {1'b1, 1'b1, 32'h300 + 32'(i)}) begin
                n_err++; $display("FAIL full_drain%0d: v=%b src=%0d res=%h want 1 1 %h",
                                  i, valid_w_o, src_w_o, result_w_o, 32'h300 + i);
            end
        end
        n_cmp++;
        if (ready_o !== 2'b11) begin
            n_err++; $display("FAIL full_ready_after: got %b want 11", ready_o);
        end
        tick();
        n_cmp++;
        if ({valid_w_o, result_w_o} !== {1'b0, 32'h0}) begin
            n_err++; $display("FAIL full_no_dead: v=%b res=%h want 0 0", valid_w_o, result_w_o);
        end
    endtask

    task automatic test_stall();
        do_reset();
        stall_w_i = 1'b0;
        drive(0, 32'h0, 32'h400, 5'd2, 1'b1);
        tick();
        drive(0, 32'h0, 32'h401, 5'd2, 1'b1);
        tick();
        stall_w_i = 1'b1;
        #1;
        n_cmp++;
        if ({valid_w_o, retire_w_o} !== 2'b10) begin
            n_err++; $display("FAIL stall_retire: v=%b ret=%b want 1 0", valid_w_o, retire_w_o);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h0, 32'h402 + i, 5'd2, 1'b1);
            tick();
            n_cmp++;
            if ({valid_w_o, retire_w_o, result_w_o, src_w_o} !== {1'b1, 1'b0, 32'h400, 1'b0}) begin
                n_err++; $display("FAIL stall_hold%0d: v=%b ret=%b res=%h src=%0d want 1 0 400 0",
                                  i, valid_w_o, retire_w_o, result_w_o, src_w_o);
            end
        end
        valid_i = '0;
        n_cmp++;
        if (ready_o !== 2'b10) begin
            n_err++; $display("FAIL stall_no_pop: ready %b want 10", ready_o);
        end
        stall_w_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({valid_w_o, retire_w_o, result_w_o} !== {1'b1, 1'b1, 32'h401 + 32'(i)}) begin
                n_err++; $display("FAIL stall_drain%0d: v=%b ret=%b res=%h want 1 1 %h",
                                  i, valid_w_o, retire_w_o, result_w_o, 32'h401 + i);
            end
        end
        tick();
        n_cmp++;
        if (valid_w_o !== 1'b0) begin
            n_err++; $display("FAIL stall_bubble: valid %b want 0", valid_w_o);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        stall_w_i = 1'b1;
        drive(0, 32'h0, 32'h600, 5'd4, 1'b1);
        tick();
        drive(0, 32'h0, 32'h601, 5'd4, 1'b1);
        tick();
        stall_w_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(0, 32'h0, 32'h602 + i, 5'd4, 1'b1);
            tick();
            n_cmp++;
            if ({valid_w_o, result_w_o, ready_o[0]} !== {1'b1, 32'h600 + 32'(i), 1'b1}) begin
                n_err++; $display("FAIL pp_same_cycle%0d: v=%b res=%h rdy=%b want 1 %h 1",
                                  i, valid_w_o, result_w_o, ready_o[0], 32'h600 + i);
            end
        end
        valid_i = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({valid_w_o, result_w_o} !== {1'b1, 32'h602 + 32'(i)}) begin
                n_err++; $display("FAIL pp_order%0d: v=%b res=%h want 1 %h", i, valid_w_o, result_w_o, 32'h602 + i);
            end
        end
        tick();
        n_cmp++;
        if (valid_w_o !== 1'b0) begin
            n_err++; $display("FAIL pp_count: valid %b want 0 (count not 2)", valid_w_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        stall_w_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(0, 32'h0, 32'h700 + i, 5'd8, 1'b1);
            drive(1, 32'h0, 32'h800 + i, 5'd9, 1'b1);
            tick();
        end
        valid_i = '0;
        stall_w_i = 1'b0;
        tick();
        n_cmp++;
        if ({valid_w_o, result_w_o} !== {1'b1, 32'h700}) begin
            n_err++; $display("FAIL mid_pre: v=%b res=%h want 1 700", valid_w_o, result_w_o);
        end
        reset_i = 1'b1;
        stall_w_i = 1'b1;
        drive(0, 32'h5, 32'hBAD, 5'd1, 1'b1);
        tick();
        reset_i = 1'b0;
        valid_i = '0;
        stall_w_i = 1'b0;
        n_cmp++;
        if ({valid_w_o, retire_w_o, reg_write_w_o, ready_o} !== 5'b00011) begin
            n_err++; $display("FAIL mid_flags: got %b want 00011", {valid_w_o, retire_w_o, reg_write_w_o, ready_o});
        end
        n_cmp++;
        if ({instr_w_o, result_w_o, rd_w_o, src_w_o} !== 70'd0) begin
            n_err++; $display("FAIL mid_fields: got %h want 0", {instr_w_o, result_w_o, rd_w_o, src_w_o});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (valid_w_o !== 1'b0) begin
                n_err++; $display("FAIL mid_stale%0d: valid %b res=%h want 0", i, valid_w_o, result_w_o);
            end
        end
    endtask

    initial begin
        reset_i = 1'b1;
        valid_i = '0;
        instr_i = '0;
        result_i = '0;
        rd_i = '0;
        reg_write_i = '0;
        stall_w_i = 1'b0;
        tick();
        tick();
        test_reset();
        test_single();
        test_fairness();
        test_full();
        test_stall();
        test_push_pop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
